// File: rtl/fft_ctrl_pkg.sv
// fft_ctrl_pkg: FSM state encoding and width helper shared by the FFT control blocks.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_state_e;

    // Width of a counter holding 0..v-1, never narrower than one bit.
    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fft_delay_line.sv
// fft_delay_line: fixed-depth register pipeline with synchronous active-low clear.
module fft_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pipe_q <= '{default: '0};
        end else begin
            pipe_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/fft_r2_stage_sequencer.sv
// fft_r2_stage_sequencer: per-stage butterfly read/twiddle issue for an in-place radix-2 DIT FFT,
// with drain bubbles between stages and write-back addresses delayed by the pipeline latency.
module fft_r2_stage_sequencer
    import fft_ctrl_pkg::*;
#(
    parameter  int N_POINTS     = 16,
    parameter  int PIPE_LATENCY = 3,
    localparam int LOG2N        = $clog2(N_POINTS),
    localparam int ADDR_WIDTH   = LOG2N,
    localparam int TW_WIDTH     = LOG2N - 1,
    localparam int STAGE_WIDTH  = clog2_min1(LOG2N)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [STAGE_WIDTH-1:0] stage,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  rd_addr_a,
    output logic [ADDR_WIDTH-1:0]  rd_addr_b,
    output logic [TW_WIDTH-1:0]    tw_idx,
    output logic                   wr_en,
    output logic [ADDR_WIDTH-1:0]  wr_addr_a,
    output logic [ADDR_WIDTH-1:0]  wr_addr_b
);

    localparam int DW = clog2_min1(PIPE_LATENCY);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_RUN   = RUN;
    localparam logic [1:0] S_DRAIN = DRAIN;
    localparam logic [1:0] S_DONE  = DONE;
    localparam logic [TW_WIDTH-1:0]    B_LAST = TW_WIDTH'(N_POINTS / 2 - 1);
    localparam logic [STAGE_WIDTH-1:0] S_LAST = STAGE_WIDTH'(LOG2N - 1);
    localparam logic [DW-1:0]          D_LAST = DW'(PIPE_LATENCY - 1);

    logic [1:0]             state_q, state_d;
    logic [STAGE_WIDTH-1:0] stage_q, stage_d;
    logic [TW_WIDTH-1:0]    b_q, b_d;
    logic [DW-1:0]          dcnt_q, dcnt_d;
    logic                   busy_q, done_q, rd_en_q;
    logic [ADDR_WIDTH-1:0]  ra_q, rb_q;
    logic [TW_WIDTH-1:0]    tw_q;
    logic                   run_d;
    logic [ADDR_WIDTH-1:0]  bx, span, pos, addr_a, addr_b;
    logic [TW_WIDTH-1:0]    tw;

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        b_d     = b_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_RUN;
                stage_d = '0;
                b_d     = '0;
            end
            S_RUN: begin
                state_d = (b_q == B_LAST) ? S_DRAIN : S_RUN;
                b_d     = (b_q == B_LAST) ? '0 : b_q + 1'b1;
                dcnt_d  = '0;
            end
            S_DRAIN: if (dcnt_q == D_LAST) begin
                state_d = (stage_q == S_LAST) ? S_DONE : S_RUN;
                stage_d = (stage_q == S_LAST) ? stage_q : stage_q + 1'b1;
            end else begin
                dcnt_d = dcnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Addresses are built from next-state counters so the issued tuple is registered with rd_en.
    always_comb begin
        run_d  = (state_d == S_RUN);
        bx     = ADDR_WIDTH'(b_d);
        span   = ADDR_WIDTH'(1) << stage_d;
        pos    = bx & (span - 1'b1);
        addr_a = ((bx - pos) << 1) + pos;
        addr_b = addr_a + span;
        tw     = TW_WIDTH'(pos << (TW_WIDTH - 32'(stage_d)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            stage_q <= '0;
            b_q     <= '0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            ra_q    <= '0;
            rb_q    <= '0;
            tw_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            b_q     <= b_d;
            dcnt_q  <= dcnt_d;
            busy_q  <= run_d || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
            rd_en_q <= run_d;
            ra_q    <= run_d ? addr_a : '0;
            rb_q    <= run_d ? addr_b : '0;
            tw_q    <= run_d ? tw : '0;
        end
    end

    fft_delay_line #(
        .WIDTH(1 + 2 * ADDR_WIDTH),
        .DEPTH(PIPE_LATENCY)
    ) u_wr_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  ({rd_en_q, ra_q, rb_q}),
        .q_o  ({wr_en, wr_addr_a, wr_addr_b})
    );

    assign busy      = busy_q;
    assign done      = done_q;
    assign stage     = stage_q;
    assign rd_en     = rd_en_q;
    assign rd_addr_a = ra_q;
    assign rd_addr_b = rb_q;
    assign tw_idx    = tw_q;

endmodule

// File: doc/fft_r2_stage_sequencer.md
# fft_r2_stage_sequencer

Control sequencer for an iterative, in-place radix-2 DIT FFT built around one shared butterfly datapath and a dual-port sample RAM. For each stage it issues one butterfly per cycle: two read addresses plus a twiddle-ROM index. It delays those addresses through the RAM + butterfly pipeline latency to produce the matching write-back. It also inserts drain bubbles between stages so that no read overtakes an outstanding write. It sits between the FFT top-level start/done handshake and the memory/butterfly/twiddle-ROM datapath.

## Interface
- N_POINTS, 16: transform size; power of two, ≥ 4.
- PIPE_LATENCY, 3: cycles from read issue to write-back (1 RAM read + 2 butterfly); ≥ 1.
- Derived: LOG2N = $clog2(N_POINTS); ADDR_WIDTH = LOG2N; TW_WIDTH = LOG2N-1; STAGE_WIDTH = max(1, $clog2(LOG2N)).

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-low.
- start  in  1  begin transform; sampled only in IDLE.
- busy  out  1  high from first issue cycle through last write cycle.
- done  out  1  one-cycle pulse after final write.
- stage  out  STAGE_WIDTH  current issuing stage (0..LOG2N-1).
- rd_en  out  1  issue butterfly read this cycle.
- rd_addr_a / rd_addr_b  out  ADDR_WIDTH  upper/lower operand addresses.
- tw_idx  out  TW_WIDTH  twiddle ROM index; valid with rd_en.
- wr_en  out  1  write butterfly results this cycle.
- wr_addr_a / wr_addr_b  out  ADDR_WIDTH  write-back addresses; out0→a, out1→b.

## Operation
- FSM: IDLE, RUN, DRAIN, DONE.
  - IDLE: start=1 → RUN. The stage counter and the butterfly counter b are cleared.
  - RUN: rd_en=1 every cycle. When b = N/2-1: go to DRAIN and clear b; otherwise increment b.
  - DRAIN: counts PIPE_LATENCY cycles with rd_en=0. On exit, go to RUN with stage+1, or go to DONE if stage = LOG2N-1.
  - DONE: done=1 for one cycle, then IDLE.
- Address generation for stage s:
  - span = 2^s; group = b >> s; pos = b & (span-1).
  - rd_addr_a = group·2·span + pos; rd_addr_b = rd_addr_a + span.
  - tw_idx = pos << (LOG2N-1-s).
  - All arithmetic is unsigned at ADDR_WIDTH bits; no wrap occurs by construction.
- Write side: {wr_en, wr_addr_a, wr_addr_b} equal {rd_en, rd_addr_a, rd_addr_b} delayed exactly PIPE_LATENCY cycles. The delay line is cleared on reset.
- Input samples are bit-reversed in RAM before start; output is natural order. The datapath aligns in0 with the twiddle product; that alignment is not this block's concern.
- start while busy or in DONE: ignored; no queuing. start held high: a new transform begins on the cycle after DONE returns to IDLE (IDLE sample).
- Reset mid-operation: the next cycle has all outputs 0 and state IDLE. Pending delay-line writes are discarded, so wr_en never asserts afterwards.

## Timing
- Reset values: busy, done, rd_en, wr_en, all addresses, tw_idx and stage = 0.
- All outputs are registered.
- Cycle numbering: start sampled in IDLE at cycle 0.
  - First rd_en is at cycle 1.
  - Stage s issues cycles 1+s·(N/2+L) through s·(N/2+L)+N/2, where L = PIPE_LATENCY.
- Hazard rule: the first read of stage s+1 occurs exactly 1 cycle after the last write of stage s. The RAM does not need write-first behaviour.
- Final write at cycle LOG2N·(N/2+L).
- done pulses at cycle LOG2N·(N/2+L)+1, and busy=0 in that same cycle. Defaults give a final write at cycle 44 and done at cycle 45.
- Throughput: one butterfly/cycle in RUN.

## Structure
- Package fft_ctrl_pkg: the state enum (IDLE/RUN/DRAIN/DONE) and a localparam helper for clog2-derived widths. Shared with the future memory-based FFT top.
- One sub-module: fft_delay_line (parameters WIDTH, DEPTH; synchronous active-low clear). It carries {rd_en, rd_addr_a, rd_addr_b} to the write port. It is reusable for the in0 alignment path in the datapath wrapper.
- The FSM, counters and address generator live in the top module.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with start=1 → every output is 0 and busy stays 0 until a start is sampled after release.
- Defaults, single start, stage 0 → issues (0,1,tw0), (2,3,tw0)…(14,15,tw0). Stage 1, b=1 → (1,3,tw4). Stage 3, b=7 → (7,15,tw7). Total rd_en count = 32.
- Write alignment and hazard → each wr tuple equals the rd tuple 3 cycles earlier, and no stage-s+1 read occurs before the last stage-s write. Final write at cycle 44, done at cycle 45.
- start pulsed at cycles 5 and 45 while busy/DONE → ignored. start held continuously → the second transform's first rd_en occurs 2 cycles after done.
- rst_n=0 for 1 cycle during stage 2 → next cycle all outputs 0, no further wr_en. A subsequent start completes in the full 45 cycles.
- N_POINTS=8, PIPE_LATENCY=2 → stage 2 issues (0,4,tw0)…(3,7,tw3), done at cycle 19.
